pic10_pmem_arbiter: RTL and testbench
=====================================

# pic10_pmem_arbiter

Arbiter and sequencer for the PIC10 program store. It shares the single 512x12 program memory between CPU instruction fetch and an external loader port used for in-system reprogramming. The arbiter halts the CPU at an instruction boundary, grants the loader exclusive write access, and restarts the CPU from the reset vector when loading completes. It sits between `pic10_cpu`'s fetch interface and the program store.

## Interface
- `ADDR_W`, 9: program address width (512 words).
- `INSTR_W`, 12: instruction width.
- `DRAIN_TIMEOUT`, 15: maximum cycles in DRAIN before a forced grant; range 1..255.
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset; one clock domain.
- `cpu_pc_addr`  in  ADDR_W: CPU fetch address (`pc_bus`).
- `cpu_halted`  in  1: controller reports it is stalled at a fetch boundary.
- `cpu_instr`  out  INSTR_W: instruction to CPU (`program_bus`).
- `cpu_hold`  out  1: request the controller to stall at its next fetch.
- `cpu_restart`  out  1: one-cycle pulse; the CPU treats it as a synchronous reset of the PC and stack.
- `ld_req`  in  1: loader access request.
- `ld_we`  in  1: 1 = write, 0 = read.
- `ld_addr`  in  ADDR_W: loader address.
- `ld_wdata`  in  INSTR_W: loader write data.
- `ld_done`  in  1: loader finished; single-cycle pulse.
- `ld_grant`  out  1: loader owns memory.
- `ld_ack`  out  1: registered access acknowledge.
- `ld_rdata`  out  INSTR_W: read data, valid with `ld_ack`.
- `ld_count`  out  ADDR_W+1: writes accepted in the current session.
- `mem_addr`  out  ADDR_W; `mem_we`  out  1; `mem_wdata`  out  INSTR_W: memory port with synchronous write.
- `mem_rdata`  in  INSTR_W: combinational read data.

## Operation
- **States:** RUN, DRAIN, LOAD, RELEASE. Reset state is RUN.
- **Reset values:** all outputs 0; `ld_rdata` 0; `ld_count` 0.
- **RUN:**
  - `mem_addr` = `cpu_pc_addr`; `cpu_instr` = `mem_rdata`; `mem_we` = 0.
  - `ld_req` = 1 → DRAIN.
- **DRAIN:**
  - `cpu_hold` = 1; the timeout counter loads `DRAIN_TIMEOUT`.
  - `cpu_halted` = 1, or the counter reaching 0 → LOAD.
  - Loader requests are ignored (no ack).
- **LOAD:**
  - `cpu_hold` = 1, `ld_grant` = 1, `mem_addr` = `ld_addr`, `cpu_instr` = 12'h000 (NOP).
  - An access is accepted when `ld_req` & !`ld_ack`. This gives at most one access per two cycles.
  - Accepted write: `mem_we` = 1 in the same cycle, `ld_ack` next cycle, `ld_count`++ (saturates at 512).
  - `ld_done` → RELEASE. If `ld_done` coincides with an accepted access, the access completes and its ack still issues.
- **RELEASE:**
  - One cycle: `cpu_restart` = 1, `cpu_hold` = 1, `ld_grant` = 0.
  - Next state is RUN; `cpu_hold` deasserts. `ld_count` holds until the next DRAIN entry, which clears it.
- `ld_done` outside LOAD is ignored.
- `reset` in any state returns to RUN immediately: hold released, and any in-flight ack is dropped.

## Timing
- CPU fetch path is combinational in RUN (zero added latency).
- `ld_req` at cycle N in RUN → `cpu_hold` = 1 at N+1.
- `cpu_halted` at cycle M in DRAIN → `ld_grant` = 1 at M+1.
- A forced grant occurs `DRAIN_TIMEOUT`+1 cycles after DRAIN entry.
- Write accepted at cycle K → memory updated at the K/K+1 edge; `ld_ack` high during K+1.
- `ld_done` at cycle D → `cpu_restart` high at D+1; `cpu_hold` low at D+2.

## Configuration
- **`PIC10_PMEM_READBACK_EN` defined:** accepted reads register `mem_rdata` into `ld_rdata` with `ld_ack` next cycle. Reads do not change `ld_count`.
- **Not defined:** reads are acked on the same schedule with `ld_rdata` = 12'hFFF, and memory is not addressed for reads.

## Structure
- `pic10_defs.vh` holds:
  - state encodings (2-bit);
  - `PIC10_NOP` = 12'h000;
  - address and instruction widths;
  - the reset vector.
- Sub-module `pic10_timeout_counter`: loadable 8-bit down-counter with `expired` output, used for DRAIN.

## Test plan
- **Fetch passthrough:** reset, RUN, `cpu_pc_addr` = 9'h005 → `cpu_instr` equals memory word 5 in the same cycle; `cpu_hold` = 0.
- **Normal load:**
  - Stimulus: `ld_req`; `cpu_halted` after 3 cycles; write 12'hA5C to 9'h1FF; then `ld_done`.
  - Expected: `ld_grant` asserts; `ld_ack` one cycle after the write; `ld_count` = 1; `cpu_restart` single pulse; RUN restored; word 511 reads 12'hA5C.
- **Drain timeout:** `ld_req` with `cpu_halted` held 0 → `ld_grant` exactly 16 cycles after DRAIN entry.
- **Readback:** with the macro, write 12'h3C7 to 9'h010, then read it → `ld_rdata` = 12'h3C7. Without the macro → 12'hFFF.
- **Simultaneous events:** `ld_done` in the same cycle as an accepted write → write lands, ack issues, then RELEASE.
- **Reset mid-LOAD:** assert `reset` after 2 writes → next cycle RUN, all outputs 0, `ld_count` = 0.

Source files
------------

// File: rtl/pic10_pmem_arbiter_pkg.sv
// rtl/pic10_pmem_arbiter_pkg.sv - shared encodings and constants for the PIC10 program-store arbiter
package pic10_pmem_arbiter_pkg;

    localparam int PIC10_ADDR_W  = 9;
    localparam int PIC10_INSTR_W = 12;

    localparam logic [PIC10_INSTR_W-1:0] PIC10_NOP          = 12'h000;
    localparam logic [PIC10_INSTR_W-1:0] PIC10_READ_FILL    = 12'hFFF;
    localparam logic [PIC10_ADDR_W-1:0]  PIC10_RESET_VECTOR = 9'h000;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_LOAD    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/pic10_timeout_counter.sv
// rtl/pic10_timeout_counter.sv - loadable 8-bit down-counter with expired flag
module pic10_timeout_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       en,
    input  logic [7:0] load_value,
    output logic       expired
);

    logic [7:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != 8'd0)) begin
            count <= count - 8'd1;
        end
    end

    assign expired = (count == 8'd0);

endmodule

// File: rtl/pic10_pmem_arbiter.sv
// rtl/pic10_pmem_arbiter.sv - shares the PIC10 program store between CPU fetch and an in-system loader
// Optional feature: PIC10_PMEM_READBACK_EN enables real loader read data.
module pic10_pmem_arbiter
    import pic10_pmem_arbiter_pkg::*;
#(
    parameter int ADDR_W        = PIC10_ADDR_W,
    parameter int INSTR_W       = PIC10_INSTR_W,
    parameter int DRAIN_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  cpu_pc_addr,
    input  logic               cpu_halted,
    output logic [INSTR_W-1:0] cpu_instr,
    output logic               cpu_hold,
    output logic               cpu_restart,
    input  logic               ld_req,
    input  logic               ld_we,
    input  logic [ADDR_W-1:0]  ld_addr,
    input  logic [INSTR_W-1:0] ld_wdata,
    input  logic               ld_done,
    output logic               ld_grant,
    output logic               ld_ack,
    output logic [INSTR_W-1:0] ld_rdata,
    output logic [ADDR_W:0]    ld_count,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_we,
    output logic [INSTR_W-1:0] mem_wdata,
    input  logic [INSTR_W-1:0] mem_rdata
);

    localparam logic [7:0]    TIMEOUT_LOAD = 8'(DRAIN_TIMEOUT);
    localparam logic [ADDR_W:0] COUNT_MAX  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] COUNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    arb_state_t state, next_state;
    logic       accept;
    logic       wr_accept;
    logic       rd_accept;
    logic       drain_entry;
    logic       drain_expired;

    // ld_ack doubles as the busy flag, spacing accesses at least two cycles apart.
    assign accept      = (state == ST_LOAD) && ld_req && !ld_ack;
    assign wr_accept   = accept && ld_we;
    assign rd_accept   = accept && !ld_we;
    assign drain_entry = (state == ST_RUN) && ld_req;

    pic10_timeout_counter u_drain_timer (
        .clk        (clk),
        .rst        (reset),
        .load       (drain_entry),
        .en         (state == ST_DRAIN),
        .load_value (TIMEOUT_LOAD),
        .expired    (drain_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        cpu_hold    = 1'b0;
        cpu_restart = 1'b0;
        ld_grant    = 1'b0;
        cpu_instr   = mem_rdata;
        mem_addr    = cpu_pc_addr;
        mem_we      = 1'b0;
        mem_wdata   = ld_wdata;
        case (state)
            ST_RUN: begin
                if (ld_req) next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                // CPU keeps fetching normally until it reports a clean halt.
                cpu_hold = 1'b1;
                if (cpu_halted || drain_expired) next_state = ST_LOAD;
            end
            ST_LOAD: begin
                cpu_hold  = 1'b1;
                ld_grant  = 1'b1;
                cpu_instr = PIC10_NOP;
`ifdef PIC10_PMEM_READBACK_EN
                mem_addr  = ld_addr;
`else
                mem_addr  = ld_we ? ld_addr : '0;
`endif
                mem_we    = wr_accept;
                if (ld_done) next_state = ST_RELEASE;
            end
            ST_RELEASE: begin
                cpu_hold    = 1'b1;
                cpu_restart = 1'b1;
                cpu_instr   = PIC10_NOP;
                mem_addr    = ADDR_W'(PIC10_RESET_VECTOR);
                next_state  = ST_RUN;
            end
            default: next_state = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_ack   <= 1'b0;
            ld_rdata <= '0;
            ld_count <= '0;
        end else begin
            ld_ack <= accept;
            if (drain_entry) begin
                ld_count <= '0;
            end else if (wr_accept && (ld_count != COUNT_MAX)) begin
                ld_count <= ld_count + COUNT_ONE;
            end
            if (rd_accept) begin
`ifdef PIC10_PMEM_READBACK_EN
                ld_rdata <= mem_rdata;
`else
                ld_rdata <= {INSTR_W{1'b1}};
`endif
            end
        end
    end

endmodule

// File: tb/tb_pic10_pmem_arbiter.sv
// tb/tb_pic10_pmem_arbiter.sv - scoreboard bench for pic10_pmem_arbiter
module tb_pic10_pmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [8:0]  cpu_pc_addr = '0;
    logic        cpu_halted = 1'b0;
    logic [11:0] cpu_instr;
    logic        cpu_hold;
    logic        cpu_restart;
    logic        ld_req = 1'b0;
    logic        ld_we = 1'b0;
    logic [8:0]  ld_addr = '0;
    logic [11:0] ld_wdata = '0;
    logic        ld_done = 1'b0;
    logic        ld_grant;
    logic        ld_ack;
    logic [11:0] ld_rdata;
    logic [9:0]  ld_count;
    logic [8:0]  mem_addr;
    logic        mem_we;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;

    logic [11:0] mem [512];

    typedef struct {
        logic        chk_rdata;
        logic [11:0] rdata;
        logic [9:0]  count;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

`ifdef PIC10_PMEM_READBACK_EN
    localparam logic [11:0] EXP_READ = 12'h3C7;
`else
    localparam logic [11:0] EXP_READ = 12'hFFF;
`endif

    pic10_pmem_arbiter #(.ADDR_W(9), .INSTR_W(12), .DRAIN_TIMEOUT(15)) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_pc_addr (cpu_pc_addr),
        .cpu_halted  (cpu_halted),
        .cpu_instr   (cpu_instr),
        .cpu_hold    (cpu_hold),
        .cpu_restart (cpu_restart),
        .ld_req      (ld_req),
        .ld_we       (ld_we),
        .ld_addr     (ld_addr),
        .ld_wdata    (ld_wdata),
        .ld_done     (ld_done),
        .ld_grant    (ld_grant),
        .ld_ack      (ld_ack),
        .ld_rdata    (ld_rdata),
        .ld_count    (ld_count),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 12'(i * 7 + 256);
    end
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    function automatic exp_t mk(input logic c, input logic [11:0] r, input logic [9:0] n);
        exp_t e;
        e.chk_rdata = c;
        e.rdata     = r;
        e.count     = n;
        return e;
    endfunction

    // Monitor: every ack must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && ld_ack) begin
            chk("ack_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_count", 32'(ld_count), 32'(e.count));
                if (e.chk_rdata) chk("ack_rdata", 32'(ld_rdata), 32'(e.rdata));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        smp;
        chk("rst_hold", 32'(cpu_hold), 0);
        chk("rst_grant", 32'(ld_grant), 0);
        chk("rst_restart", 32'(cpu_restart), 0);
        chk("rst_ack", 32'(ld_ack), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_rdata", 32'(ld_rdata), 0);
        chk("rst_count", 32'(ld_count), 0);
        reset = 1'b0;

        tick; cpu_pc_addr = 9'h005; smp;
        chk("fetch_instr", 32'(cpu_instr), 32'h123);
        chk("fetch_addr", 32'(mem_addr), 32'h005);
        chk("fetch_hold", 32'(cpu_hold), 0);

        tick; ld_req = 1; ld_we = 1; ld_addr = 9'h1FF; ld_wdata = 12'hA5C; smp;
        chk("hold_before_drain", 32'(cpu_hold), 0);
        tick; smp;
        chk("hold_n_plus_1", 32'(cpu_hold), 1);
        chk("drain_no_grant", 32'(ld_grant), 0);
        chk("drain_no_we", 32'(mem_we), 0);
        tick; smp;
        tick; cpu_halted = 1; smp;
        chk("grant_wait_halt", 32'(ld_grant), 0);
        tick; sb.push_back(mk(0, 12'h000, 10'd1)); smp;
        chk("grant_m_plus_1", 32'(ld_grant), 1);
        chk("load_we", 32'(mem_we), 1);
        chk("load_addr", 32'(mem_addr), 32'h1FF);
        chk("load_nop", 32'(cpu_instr), 0);
        chk("ack_k", 32'(ld_ack), 0);
        tick; ld_req = 0; cpu_halted = 0; smp;
        chk("ack_k_plus_1", 32'(ld_ack), 1);
        tick; ld_done = 1; smp;
        chk("restart_d", 32'(cpu_restart), 0);
        tick; ld_done = 0; smp;
        chk("restart_d1", 32'(cpu_restart), 1);
        chk("release_hold", 32'(cpu_hold), 1);
        chk("release_grant", 32'(ld_grant), 0);
        tick; cpu_pc_addr = 9'h1FF; smp;
        chk("restart_pulse_end", 32'(cpu_restart), 0);
        chk("hold_d2", 32'(cpu_hold), 0);
        chk("word511", 32'(cpu_instr), 32'hA5C);
        chk("count_held", 32'(ld_count), 1);

        tick; ld_req = 1; ld_we = 1; ld_addr = 9'h010; ld_wdata = 12'h3C7; smp;
        tick; smp;
        chk("drain2_hold", 32'(cpu_hold), 1);
        chk("drain2_count_clr", 32'(ld_count), 0);
        n = 0;
        while (!ld_grant && n < 40) begin
            tick; smp;
            n++;
        end
        chk("drain_timeout_cycles", 32'(n), 16);
        sb.push_back(mk(0, 12'h000, 10'd1));
        tick; ld_req = 0; smp;
        tick; ld_req = 1; ld_we = 0; ld_addr = 9'h010;
        sb.push_back(mk(1, EXP_READ, 10'd1)); smp;
        chk("read_no_we", 32'(mem_we), 0);
        tick; ld_req = 0; smp;

        tick; ld_req = 1; ld_we = 1; ld_addr = 9'h020; ld_wdata = 12'h7E1; ld_done = 1;
        sb.push_back(mk(0, 12'h000, 10'd2)); smp;
        chk("simul_we", 32'(mem_we), 1);
        tick; ld_req = 0; ld_done = 0; smp;
        chk("simul_ack", 32'(ld_ack), 1);
        chk("simul_restart", 32'(cpu_restart), 1);
        tick; cpu_pc_addr = 9'h020; smp;
        chk("simul_run", 32'(cpu_hold), 0);
        chk("simul_word", 32'(cpu_instr), 32'h7E1);
        chk("simul_count", 32'(ld_count), 2);

        tick; ld_done = 1; smp;
        tick; ld_done = 0; smp;
        chk("done_outside_hold", 32'(cpu_hold), 0);
        chk("done_outside_restart", 32'(cpu_restart), 0);

        cpu_halted = 1;
        tick; ld_req = 1; ld_we = 1; ld_addr = 9'h030; ld_wdata = 12'h111; smp;
        tick; smp;
        tick; sb.push_back(mk(0, 12'h000, 10'd1)); smp;
        tick; ld_req = 0; smp;
        tick; ld_req = 1; ld_addr = 9'h031; ld_wdata = 12'h222;
        sb.push_back(mk(0, 12'h000, 10'd2)); smp;
        tick; ld_req = 0; smp;
        tick; ld_req = 1; ld_addr = 9'h032; ld_wdata = 12'h333; smp;
        chk("third_write_we", 32'(mem_we), 1);
        reset = 1;
        tick; ld_req = 0; cpu_halted = 0; smp;
        chk("mid_rst_hold", 32'(cpu_hold), 0);
        chk("mid_rst_grant", 32'(ld_grant), 0);
        chk("mid_rst_ack", 32'(ld_ack), 0);
        chk("mid_rst_restart", 32'(cpu_restart), 0);
        chk("mid_rst_we", 32'(mem_we), 0);
        chk("mid_rst_count", 32'(ld_count), 0);
        chk("mid_rst_rdata", 32'(ld_rdata), 0);
        reset = 0;
        tick; cpu_pc_addr = 9'h031; smp;
        chk("word031", 32'(cpu_instr), 32'h222);
        tick; cpu_pc_addr = 9'h032; smp;
        chk("word032_untouched", 32'(cpu_instr), 32'h25E);

        tick; smp;
        chk("sb_drained", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
